baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 89 ++++++++
 tb/tb_baud_gen_frac.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N baud tick generator with oversample and bit ticks.
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          run enable; while low the counters are parked and ticks suppressed
//   div_int     integer cycles per rx tick (0 behaves as 1)
//   div_frac    fractional cycles per rx tick, units of 2^-FRAC_WIDTH
//   div_load    single-cycle strobe staging div_int/div_frac
//   div_pending staged divisor not yet active
//   rxclk_en    one-cycle oversample tick
//   txclk_en    one-cycle bit tick, every OVERSAMPLE-th rxclk_en
module baud_gen_frac #(
   parameter int DIV_WIDTH    = 16,
   parameter int FRAC_WIDTH   = 4,
   parameter int OVERSAMPLE   = 16,
   parameter int DEFAULT_DIV  = 27,
   parameter int DEFAULT_FRAC = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DIV_WIDTH-1:0]  div_int,
   input  logic [FRAC_WIDTH-1:0] div_frac,
   input  logic                  div_load,
   output logic                  div_pending,
   output logic                  rxclk_en,
   output logic                  txclk_en
);
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   logic [DIV_WIDTH-1:0]  act_int, stg_int, cnt, nxt_int, reload;
   logic [FRAC_WIDTH-1:0] act_frac, stg_frac, frac_acc;
   logic [FRAC_WIDTH:0]   sum;
   logic [OSW-1:0]        os_cnt;
   logic                  tick, tx_tick, apply, int_zero, carry;
   always_comb begin
      tick     = en && cnt == '0;
      tx_tick  = tick && os_cnt == OS_LAST;
      // staged divisor only takes effect on a bit boundary or while parked
      apply    = div_pending && (!en || tx_tick);
      nxt_int  = apply ? stg_int : act_int;
      int_zero = nxt_int == '0;
      sum      = {1'b0, frac_acc} + {1'b0, act_frac};
      // a freshly applied divisor restarts the accumulator, so no carry then
      carry    = tick && sum[FRAC_WIDTH] && !apply && !int_zero;
      reload   = int_zero ? '0 : nxt_int - DIV_WIDTH'(1) + DIV_WIDTH'(carry);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_int     <= DIV_WIDTH'(DEFAULT_DIV);
         stg_int     <= DIV_WIDTH'(DEFAULT_DIV);
         act_frac    <= FRAC_WIDTH'(DEFAULT_FRAC);
         stg_frac    <= FRAC_WIDTH'(DEFAULT_FRAC);
         cnt         <= DIV_WIDTH'(DEFAULT_DIV - 1);
         frac_acc    <= '0;
         os_cnt      <= '0;
         div_pending <= 1'b0;
         rxclk_en    <= 1'b0;
         txclk_en    <= 1'b0;
      end else begin
         if (div_load) begin
            stg_int  <= div_int;
            stg_frac <= div_frac;
         end
         if (apply) begin
            act_int  <= stg_int;
            act_frac <= stg_frac;
         end
         div_pending <= div_load || (div_pending && !apply);
         if (!en) begin
            cnt      <= reload;
            frac_acc <= '0;
            os_cnt   <= '0;
            rxclk_en <= 1'b0;
            txclk_en <= 1'b0;
         end else if (tick) begin
            cnt      <= reload;
            frac_acc <= (apply || int_zero) ? '0 : sum[FRAC_WIDTH-1:0];
            os_cnt   <= tx_tick ? '0 : os_cnt + OSW'(1);
            rxclk_en <= 1'b1;
            txclk_en <= tx_tick;
         end else begin
            cnt      <= cnt - DIV_WIDTH'(1);
            rxclk_en <= 1'b0;
            txclk_en <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: scoreboard bench for baud_gen_frac using a period-based reference model.
module tb_baud_gen_frac;
   localparam int DW = 8, FW = 4, OS = 4, DD = 4, DF = 0;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, div_load = 1'b0;
   logic [DW-1:0] div_int = '0;
   logic [FW-1:0] div_frac = '0;
   logic div_pending, rxclk_en, txclk_en;
   always #5 clk = ~clk;
   baud_gen_frac #(
      .DIV_WIDTH(DW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS),
      .DEFAULT_DIV(DD), .DEFAULT_FRAC(DF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
      .div_load(div_load), .div_pending(div_pending), .rxclk_en(rxclk_en), .txclk_en(txclk_en)
   );
   typedef struct {bit rx; bit tx; bit pend;} exp_t;
   exp_t sb[$];
   int n_vec = 0, n_err = 0;
   int m_int, m_frac, s_int, s_frac, m_acc, m_wait, m_os;
   bit m_pend, meas = 0;
   int cyc_no = 0;
   int ticks[$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_int = DD; m_frac = DF; s_int = DD; s_frac = DF;
      m_pend = 0; m_acc = 0; m_wait = DD; m_os = 0;
   endtask
   // Tracks cycles remaining until the next rx tick and picks each new period on a tick.
   task automatic model_step(output exp_t e);
      bit ap;
      int p;
      e = '{0, 0, 0};
      ap = 0;
      if (!en) begin
         if (m_pend) begin ap = 1; m_int = s_int; m_frac = s_frac; end
         m_wait = (m_int == 0) ? 1 : m_int;
         m_acc = 0;
         m_os = 0;
      end else begin
         m_wait--;
         if (m_wait == 0) begin
            e.rx = 1;
            e.tx = (m_os == OS - 1);
            m_os = (m_os + 1) % OS;
            if (e.tx && m_pend) begin ap = 1; m_int = s_int; m_frac = s_frac; end
            if (m_int == 0) begin p = 1; m_acc = 0; end
            else if (ap) begin p = m_int; m_acc = 0; end
            else begin
               m_acc += m_frac;
               p = m_int + (m_acc >> FW);
               m_acc = m_acc % (1 << FW);
            end
            m_wait = p;
         end
      end
      if (div_load) begin s_int = div_int; s_frac = div_frac; m_pend = 1; end
      else if (ap) m_pend = 0;
      e.pend = m_pend;
   endtask
   task automatic step();
      exp_t e, q;
      model_step(e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      q = sb.pop_front();
      chk("rxclk_en", rxclk_en, q.rx);
      chk("txclk_en", txclk_en, q.tx);
      chk("div_pending", div_pending, q.pend);
      cyc_no++;
      if (meas && rxclk_en) ticks.push_back(cyc_no);
      @(negedge clk);
      div_load = 1'b0;
   endtask
   task automatic run(input int n);
      repeat (n) step();
   endtask
   task automatic load(input int i, input int f);
      div_int = DW'(i);
      div_frac = FW'(f);
      div_load = 1'b1;
      step();
   endtask
   initial begin
      model_reset();
      @(negedge clk);
      chk("rst_rx", rxclk_en, 0);
      chk("rst_tx", txclk_en, 0);
      chk("rst_pend", div_pending, 0);
      rst_n = 1'b1;
      run(2);
      en = 1'b1;
      run(40);
      run(3);
      load(7, 0);
      run(5);
      load(6, 0);
      run(70);
      load(4, 8);
      run(3);
      en = 1'b0;
      run(3);
      en = 1'b1;
      meas = 1;
      run(100);
      meas = 0;
      if (ticks.size() >= 17) chk("span16", ticks[16] - ticks[0], 72);
      else chk("span16_ticks", ticks.size(), 17);
      load(9, 0);
      en = 1'b0;
      load(5, 0);
      run(2);
      en = 1'b1;
      run(30);
      load(0, 0);
      run(80);
      load(4, 0);
      run(40);
      run(7);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_rx", rxclk_en, 0);
      chk("arst_tx", txclk_en, 0);
      chk("arst_pend", div_pending, 0);
      model_reset();
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run(40);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
